tdm_demux: RTL and testbench

Time-division demultiplexer that accepts a single time-multiplexed sample stream and steers each sample to one of `N_CH` registered output channels. Frame alignment comes from a `sync` marker on the channel-0 sample. The block is the receive-side counterpart of the team's 2:1/N:1 multiplexers. It sits after a TDM link or shared bus and restores per-channel data with a valid strobe per channel.

---
 rtl/tdm_demux_pkg.sv | 15 +
 rtl/tdm_demux_mod_n_counter.sv | 45 ++++
 rtl/tdm_demux.sv | 96 +++++++++
 tb/tb_tdm_demux.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer slice: FSM state encoding and
// the counter-width helper used by the channel counter.
package tdm_demux_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_mod_n_counter.sv
// Modulo-N slot counter with a synchronous load-to-1 used for frame
// (re)alignment; wrap flags the increment out of slot N-1.
module mod_n_counter
    import tdm_demux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load0,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_q, count_d;

    // load0 wins over en: a realigning sample always lands in slot 0.
    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (load0) begin
            count_d = CW'(1);
        end else if (en) begin
            if (count_q == CW'(N - 1)) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: aligns on a sync-marked channel-0 sample and steers each
// valid sample into a registered per-channel output with a one-cycle strobe.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [N_CH*W-1:0] dout,
    output logic [N_CH-1:0]   dout_valid,
    output logic              frame_done,
    output logic              locked,
    output logic              sync_err
);

    localparam int unsigned CW = cnt_width(N_CH);

    state_t                     state_q, state_d;
    logic   [CW-1:0]            ch;
    logic                       wrap;
    logic                       cnt_en, cnt_load0;
    logic   [N_CH-1:0]          we;
    logic   [N_CH-1:0][W-1:0]   chan_q, chan_d;
    logic   [N_CH-1:0]          dout_valid_q;
    logic                       frame_done_q, frame_done_d;
    logic                       sync_err_q, sync_err_d;

    mod_n_counter #(.N(N_CH)) u_ch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .load0 (cnt_load0),
        .count (ch),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (din_valid && sync) begin
            state_d = ST_LOCKED;
        end
    end

    // Any valid sync (re)starts a frame at slot 0; in LOCKED an expected sync
    // (ch==0) behaves exactly like a normal increment, so no special case.
    always_comb begin
        cnt_load0    = din_valid && sync;
        cnt_en       = din_valid && !sync && (state_q == ST_LOCKED);
        frame_done_d = wrap;
        sync_err_d   = cnt_load0 && (state_q == ST_LOCKED) && (ch != '0);
        we           = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            we[k] = (cnt_load0 && (k == 0)) || (cnt_en && (ch == CW'(k)));
        end
        chan_d = chan_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (we[k]) begin
                chan_d[k] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q       <= '0;
            dout_valid_q <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            chan_q       <= chan_d;
            dout_valid_q <= we;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = chan_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: a slot-level reference model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_tdm_demux;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;
    localparam time         TCLK = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0]      din = '0;
    logic              din_valid = 1'b0;
    logic              sync = 1'b0;
    logic [N_CH*W-1:0] dout;
    logic [N_CH-1:0]   dout_valid;
    logic              frame_done;
    logic              locked;
    logic              sync_err;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #(TCLK / 2) clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which slot the next sample belongs to, whether we have
    // seen a frame start, and the last value written to each channel.
    bit           m_lk;
    int           m_ch;
    logic [W-1:0] m_chan [N_CH];
    logic [N_CH-1:0] m_dv;
    bit           m_fd, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lk = 0; m_ch = 0; m_dv = '0; m_fd = 0; m_err = 0;
            for (int k = 0; k < N_CH; k++) m_chan[k] = '0;
        end else begin
            m_dv = '0; m_fd = 0; m_err = 0;
            if (din_valid) begin
                if (sync) begin
                    m_err     = m_lk && (m_ch != 0);
                    m_chan[0] = din;
                    m_dv[0]   = 1'b1;
                    m_ch      = 1;
                    m_lk      = 1;
                end else if (m_lk) begin
                    m_chan[m_ch] = din;
                    m_dv[m_ch]   = 1'b1;
                    m_fd         = (m_ch == N_CH - 1);
                    m_ch         = (m_ch + 1) % N_CH;
                end
            end
        end
    end

    function automatic logic [N_CH*W-1:0] model_dout();
        logic [N_CH*W-1:0] r;
        for (int k = 0; k < N_CH; k++) r[k*W +: W] = m_chan[k];
        return r;
    endfunction

    int  obs_strobes = 0;
    int  obs_fd      = 0;
    int  obs_err     = 0;
    time fd_times[$];

    always @(negedge clk) begin
        check("dout",       64'(dout),       64'(model_dout()));
        check("dout_valid", 64'(dout_valid), 64'(m_dv));
        check("frame_done", 64'(frame_done), 64'(m_fd));
        check("locked",     64'(locked),     64'(m_lk));
        check("sync_err",   64'(sync_err),   64'(m_err));
        obs_strobes += $countones(dout_valid);
        if (frame_done === 1'b1) begin
            obs_fd++;
            fd_times.push_back($time);
        end
        if (sync_err === 1'b1) obs_err++;
    end

    task automatic send(input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = v;
        sync      = s;
        din       = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0);
    endtask

    // Assert reset between edges and confirm everything clears without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        din_valid = 1'b0;
        sync = 1'b0;
        #1;
        check("rst_dout",       64'(dout),       64'h0);
        check("rst_dout_valid", 64'(dout_valid), 64'h0);
        check("rst_frame_done", 64'(frame_done), 64'h0);
        check("rst_locked",     64'(locked),     64'h0);
        check("rst_sync_err",   64'(sync_err),   64'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic settle();
        idle(2);
        #1;
    endtask

    int s0, f0, e0;
    logic v, s;

    initial begin
        // Reset then lock on a back-to-back frame
        do_reset();
        s0 = obs_strobes; f0 = obs_fd; e0 = obs_err;
        send(1, 1, 8'h11); send(1, 0, 8'h22); send(1, 0, 8'h33); send(1, 0, 8'h44);
        settle();
        check("lock_dout",    64'(dout),  64'h44332211);
        check("lock_locked",  64'(locked), 64'h1);
        check("lock_strobes", 64'(obs_strobes - s0), 64'd4);
        check("lock_fd",      64'(obs_fd - f0), 64'd1);
        check("lock_err",     64'(obs_err - e0), 64'd0);

        // Hunt discards unsynced samples
        do_reset();
        s0 = obs_strobes;
        send(1, 0, 8'hAA); send(1, 0, 8'hBB);
        settle();
        check("hunt_no_strobe", 64'(obs_strobes - s0), 64'd0);
        check("hunt_locked",    64'(locked), 64'h0);
        send(1, 1, 8'h01);
        settle();
        check("hunt_dout",   64'(dout), 64'h00000001);
        check("hunt_strobe", 64'(obs_strobes - s0), 64'd1);

        // Gapped frame
        do_reset();
        s0 = obs_strobes; f0 = obs_fd;
        send(1, 1, 8'h11); idle(2);
        send(1, 0, 8'h22); idle(2);
        send(1, 0, 8'h33); idle(2);
        send(1, 0, 8'h44);
        settle();
        check("gap_dout",    64'(dout), 64'h44332211);
        check("gap_strobes", 64'(obs_strobes - s0), 64'd4);
        check("gap_fd",      64'(obs_fd - f0), 64'd1);

        // Misplaced sync while locked (counter is at slot 0 here)
        f0 = obs_fd; e0 = obs_err;
        send(1, 1, 8'h10); send(1, 0, 8'h20); send(1, 1, 8'h30);
        settle();
        check("resync_err",  64'(obs_err - e0), 64'd1);
        check("resync_ch0",  64'(dout[7:0]), 64'h30);
        check("resync_ch1",  64'(dout[15:8]), 64'h20);
        check("resync_fd",   64'(obs_fd - f0), 64'd0);
        check("resync_lock", 64'(locked), 64'h1);
        send(1, 0, 8'h55);
        settle();
        check("resync_next_ch1", 64'(dout[15:8]), 64'h55);

        // Three continuous frames
        do_reset();
        fd_times.delete();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N_CH; k++)
                send(1, k == 0, 8'(f * 16 + k + 1));
        settle();
        check("frames_fd", 64'(fd_times.size()), 64'd3);
        if (fd_times.size() == 3) begin
            check("frames_gap1", 64'(fd_times[1] - fd_times[0]), 64'(4 * TCLK));
            check("frames_gap2", 64'(fd_times[2] - fd_times[1]), 64'(4 * TCLK));
        end
        check("frames_dout", 64'(dout), 64'h24232221);

        // Reset mid-frame, then re-hunt
        do_reset();
        send(1, 1, 8'hA1); send(1, 0, 8'hA2);
        do_reset();
        send(1, 0, 8'hB1); send(1, 0, 8'hB2);
        settle();
        check("rehunt_locked", 64'(locked), 64'h0);
        check("rehunt_dout",   64'(dout), 64'h0);
        send(1, 1, 8'hC1);
        settle();
        check("rehunt_relock", 64'(locked), 64'h1);
        check("rehunt_ch0",    64'(dout), 64'h000000C1);

        // Random traffic: mostly aligned syncs, occasional misplaced ones and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            v = ($urandom_range(0, 9) < 7);
            if (m_ch == 0) s = ($urandom_range(0, 3) != 0);
            else           s = ($urandom_range(0, 15) == 0);
            send(v, s, W'($urandom));
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
